// File: rtl/noc_ni_tx.sv
// Network-interface transmitter: buffers core flits in a FIFO and injects them
// in order into one router input port under credit-based flow control.
module noc_ni_tx #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CREDITS = 2,
    parameter int unsigned CW      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [15:0]              req_data,
    input  logic [1:0]               req_dest,
    output logic                     out_valid,
    output logic [15:0]              out_data,
    output logic [1:0]               out_dest,
    input  logic                     credit_return,
    output logic [CW-1:0]            credit_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     credit_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [1:0]  dest;
        logic [15:0] data;
    } flit_t;

    flit_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_c;
    logic           send_c;
    logic [LW-1:0]  level_next_c;

    // Handshake and send qualification derive only from registered state and rst.
    assign req_ready = !rst && (fifo_level < LW'(DEPTH));
    assign push_c    = req_valid && req_ready;
    assign send_c    = !rst && (fifo_level != '0) && (credit_cnt != '0);

    // Occupancy update: a simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_next_c = fifo_level;
        if (push_c && !send_c) begin
            level_next_c = fifo_level + LW'(1);
        end else if (!push_c && send_c) begin
            level_next_c = fifo_level - LW'(1);
        end
    end

    // Flit storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{dest: req_dest, data: req_data};
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (send_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_next_c;
        end
    end

    // Injection register: payload holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
        end else begin
            out_valid <= send_c;
            if (send_c) begin
                out_data <= mem[rd_ptr].data;
                out_dest <= mem[rd_ptr].dest;
            end
        end
    end

    // Credit counter saturates at CREDITS; an excess return latches credit_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else if (send_c && !credit_return) begin
            credit_cnt <= credit_cnt - CW'(1);
        end else if (!send_c && credit_return) begin
            if (credit_cnt == CW'(CREDITS)) begin
                credit_err <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Testbench for noc_ni_tx: directed vector table, wrap-around stream, and a
// randomized run checked against a queue-based reference model.
module tb_noc_ni_tx;

    localparam int DEPTH   = 4;
    localparam int CREDITS = 2;
    localparam int CW      = 3;
    localparam int LW      = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [15:0]    req_data;
    logic [1:0]     req_dest;
    logic           out_valid;
    logic [15:0]    out_data;
    logic [1:0]     out_dest;
    logic           credit_return;
    logic [CW-1:0]  credit_cnt;
    logic [LW-1:0]  fifo_level;
    logic           credit_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic [17:0] mq[$];
    int          m_cred = CREDITS;
    bit          m_err  = 1'b0;
    bit          m_ov   = 1'b0;
    logic [15:0] m_od   = '0;
    logic [1:0]  m_odst = '0;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [15:0] d;
        logic [1:0]  dst;
        bit          cr;
        bit          ov;
        logic [15:0] od;
        logic [1:0]  odst;
        int          cnt;
        int          lvl;
        bit          rdy;
        bit          err;
    } vec_t;

    vec_t tbl[$];

    noc_ni_tx #(.DEPTH(DEPTH), .CREDITS(CREDITS), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .req_dest      (req_dest),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_dest      (out_dest),
        .credit_return (credit_return),
        .credit_cnt    (credit_cnt),
        .fifo_level    (fifo_level),
        .credit_err    (credit_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // Behavioural model: queue of flits, integer credit pool, saturating on excess return.
    function automatic void model_edge();
        bit          rdy;
        bit          snd;
        logic [17:0] f;
        rdy = !rst && (mq.size() < DEPTH);
        snd = !rst && (mq.size() > 0) && (m_cred > 0);
        if (rst) begin
            mq.delete();
            m_cred = CREDITS;
            m_err  = 1'b0;
            m_ov   = 1'b0;
            m_od   = '0;
            m_odst = '0;
        end else begin
            m_ov = snd;
            if (snd) begin
                f      = mq.pop_front();
                m_odst = f[17:16];
                m_od   = f[15:0];
            end
            if (req_valid && rdy) begin
                mq.push_back({req_dest, req_data});
            end
            m_cred = m_cred - int'(snd) + int'(credit_return);
            if (m_cred > CREDITS) begin
                m_cred = CREDITS;
                m_err  = 1'b1;
            end
        end
    endfunction

    task automatic drive(input bit r, input bit v, input logic [15:0] d,
                         input logic [1:0] ds, input bit cr);
        rst           = r;
        req_valid     = v;
        req_data      = d;
        req_dest      = ds;
        credit_return = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"},  int'(out_valid),  int'(m_ov));
        chk({tag, ".out_data"},   int'(out_data),   int'(m_od));
        chk({tag, ".out_dest"},   int'(out_dest),   int'(m_odst));
        chk({tag, ".credit_cnt"}, int'(credit_cnt), m_cred);
        chk({tag, ".fifo_level"}, int'(fifo_level), mq.size());
        chk({tag, ".req_ready"},  int'(req_ready),  int'(!rst && (mq.size() < DEPTH)));
        chk({tag, ".credit_err"}, int'(credit_err), int'(m_err));
    endtask

    function automatic void add(input bit r, input bit v, input logic [15:0] d,
                                input logic [1:0] ds, input bit cr, input bit ov,
                                input logic [15:0] od, input logic [1:0] ods,
                                input int cnt, input int lvl, input bit rdy, input bit err);
        vec_t t;
        t.rst = r;  t.vld = v;  t.d = d;    t.dst = ds;  t.cr = cr;
        t.ov = ov;  t.od = od;  t.odst = ods; t.cnt = cnt; t.lvl = lvl;
        t.rdy = rdy; t.err = err;
        tbl.push_back(t);
    endfunction

    initial begin
        logic [15:0] got_d[$];
        logic [1:0]  got_ds[$];
        int          first_cyc;
        int          last_cyc;

        drive(1'b1, 1'b0, '0, '0, 1'b0);

        // rst vld data dest cr | ov od odst cnt lvl rdy err
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 2, 0, 0, 0);
        add(0, 1, 16'hA5A5, 2, 0,  0, 16'h0000, 0, 2, 1, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  1, 16'hA5A5, 2, 1, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 16'hA5A5, 2, 1, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 16'hA5A5, 2, 2, 0, 1, 0);
        add(0, 1, 16'h0001, 0, 0,  0, 16'hA5A5, 2, 2, 1, 1, 0);
        add(0, 1, 16'h0002, 1, 0,  1, 16'h0001, 0, 1, 1, 1, 0);
        add(0, 1, 16'h0003, 3, 0,  1, 16'h0002, 1, 0, 1, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 16'h0002, 1, 0, 1, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 16'h0002, 1, 0, 1, 1, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 16'h0002, 1, 1, 1, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  1, 16'h0003, 3, 0, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 16'h0003, 3, 0, 0, 1, 0);
        add(0, 1, 16'h0100, 0, 0,  0, 16'h0003, 3, 0, 1, 1, 0);
        add(0, 1, 16'h0101, 1, 0,  0, 16'h0003, 3, 0, 2, 1, 0);
        add(0, 1, 16'h0102, 2, 0,  0, 16'h0003, 3, 0, 3, 1, 0);
        add(0, 1, 16'h0103, 3, 0,  0, 16'h0003, 3, 0, 4, 0, 0);
        add(0, 1, 16'h0BAD, 0, 0,  0, 16'h0003, 3, 0, 4, 0, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 16'h0003, 3, 1, 4, 0, 0);
        add(0, 0, 16'h0000, 0, 1,  1, 16'h0100, 0, 1, 3, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  1, 16'h0101, 1, 0, 2, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 16'h0101, 1, 0, 2, 1, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 16'h0101, 1, 1, 2, 1, 0);
        add(0, 0, 16'h0000, 0, 1,  1, 16'h0102, 2, 1, 1, 1, 0);
        add(0, 0, 16'h0000, 0, 1,  1, 16'h0103, 3, 1, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 16'h0103, 3, 2, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 1,  0, 16'h0103, 3, 2, 0, 1, 1);
        add(0, 0, 16'h0000, 0, 0,  0, 16'h0103, 3, 2, 0, 1, 1);
        add(0, 1, 16'h0200, 0, 0,  0, 16'h0103, 3, 2, 1, 1, 1);
        add(0, 1, 16'h0201, 1, 0,  1, 16'h0200, 0, 1, 1, 1, 1);
        add(0, 1, 16'h0202, 2, 0,  1, 16'h0201, 1, 0, 1, 1, 1);
        add(0, 1, 16'h0203, 3, 0,  0, 16'h0201, 1, 0, 2, 1, 1);
        add(0, 1, 16'h0204, 0, 0,  0, 16'h0201, 1, 0, 3, 1, 1);
        add(1, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 2, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 2, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 2, 0, 1, 0);

        // Directed vectors
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].d, tbl[i].dst, tbl[i].cr);
            tick();
            chk($sformatf("vec%0d.out_valid", i),  int'(out_valid),  int'(tbl[i].ov));
            chk($sformatf("vec%0d.out_data", i),   int'(out_data),   int'(tbl[i].od));
            chk($sformatf("vec%0d.out_dest", i),   int'(out_dest),   int'(tbl[i].odst));
            chk($sformatf("vec%0d.credit_cnt", i), int'(credit_cnt), tbl[i].cnt);
            chk($sformatf("vec%0d.fifo_level", i), int'(fifo_level), tbl[i].lvl);
            chk($sformatf("vec%0d.req_ready", i),  int'(req_ready),  int'(tbl[i].rdy));
            chk($sformatf("vec%0d.credit_err", i), int'(credit_err), int'(tbl[i].err));
        end

        // Wrap-around stream of 10 flits with a credit returned every cycle
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        first_cyc = -1;
        last_cyc  = -1;
        for (int i = 0; i < 16; i++) begin
            if (i < 10) drive(1'b0, 1'b1, 16'(16'h0010 + i), 2'(i % 4), 1'b1);
            else        drive(1'b0, 1'b0, '0, '0, 1'b1);
            tick();
            check_model("wrap");
            if (out_valid) begin
                got_d.push_back(out_data);
                got_ds.push_back(out_dest);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
        chk("wrap.count", got_d.size(), 10);
        chk("wrap.span", last_cyc - first_cyc, 9);
        for (int i = 0; i < 10 && i < got_d.size(); i++) begin
            chk($sformatf("wrap.data%0d", i), int'(got_d[i]), 16'h0010 + i);
            chk($sformatf("wrap.dest%0d", i), int'(got_ds[i]), i % 4);
        end

        // Randomized traffic against the reference model
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        tick();
        check_model("rnd_rst");
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6),
                  16'($urandom), 2'($urandom), ($urandom_range(0, 9) < 3));
            tick();
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
